// File: rtl/div_seq_ctrl.sv
// Sequencer between the EX stage and the iterative divider: accepts one DIV/DIVU at a time,
// launches the divider, holds the result for writeback, and handles divide-by-zero, flush and a done watchdog.
module div_seq_ctrl #(
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 40,
   localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
   input  logic              cpu_clk,
   input  logic              cpu_rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_signed,
   input  logic [DATA_W-1:0] req_dividend,
   input  logic [DATA_W-1:0] req_divisor,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              flush,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_quot,
   output logic [DATA_W-1:0] resp_rem,
   output logic [TAG_W-1:0]  resp_tag,
   output logic              busy,
   output logic              err_timeout,
   output logic              div_start,
   output logic              div_signed,
   output logic [DATA_W-1:0] div_dividend,
   output logic [DATA_W-1:0] div_divisor,
   input  logic              div_done,
   input  logic [DATA_W-1:0] div_quot,
   input  logic [DATA_W-1:0] div_rem
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   dividend_q, dividend_d;
   logic [DATA_W-1:0]   divisor_q, divisor_d;
   logic                signed_q, signed_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [DATA_W-1:0]   quot_q, quot_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                rvalid_q, rvalid_d;
   logic                wdog_hit_s;

   assign wdog_hit_s = (cnt_q == CNT_W'(TIMEOUT));

   // Next-state, operand/result capture and watchdog logic
   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      signed_d   = signed_q;
      tag_d      = tag_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && !flush) begin
               dividend_d = req_dividend;
               divisor_d  = req_divisor;
               signed_d   = req_signed;
               tag_d      = req_tag;
               // Divide-by-zero never reaches the divider; result is architecturally fixed
               if (req_divisor == {DATA_W{1'b0}}) begin
                  quot_d  = {DATA_W{1'b1}};
                  rem_d   = req_dividend;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_LAUNCH;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (div_done) begin
               if (flush) begin
                  state_d = ST_IDLE;
               end else begin
                  quot_d  = div_quot;
                  rem_d   = div_rem;
                  state_d = ST_RESP;
               end
            end else if (flush) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = ST_DRAIN;
            end else if (wdog_hit_s) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            // The divider cannot be aborted, so its late completion is swallowed here
            if (div_done) begin
               state_d = ST_IDLE;
            end else if (wdog_hit_s) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (flush || resp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up with state_q
   always_comb begin
      ready_d  = (state_d == ST_IDLE);
      busy_d   = (state_d != ST_IDLE);
      rvalid_d = (state_d == ST_RESP);
   end

   // State, datapath and status registers
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state_q    <= ST_IDLE;
         dividend_q <= {DATA_W{1'b0}};
         divisor_q  <= {DATA_W{1'b0}};
         signed_q   <= 1'b0;
         tag_q      <= {TAG_W{1'b0}};
         quot_q     <= {DATA_W{1'b0}};
         rem_q      <= {DATA_W{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         err_q      <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         signed_q   <= signed_d;
         tag_q      <= tag_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         rvalid_q   <= rvalid_d;
      end
   end

   // A flush in the launch cycle must keep the divider from ever starting
   assign div_start    = (state_q == ST_LAUNCH) && !flush;
   assign req_ready    = ready_q;
   assign busy         = busy_q;
   assign resp_valid   = rvalid_q;
   assign resp_quot    = quot_q;
   assign resp_rem     = rem_q;
   assign resp_tag     = tag_q;
   assign err_timeout  = err_q;
   assign div_signed   = signed_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: stub divider with programmable latency, response
// scoreboard driven by an arithmetic model, and directed scenarios with literal expectations.
module tb_div_seq_ctrl;

   localparam int T = 40;

   logic        clk, rstn;
   logic        req_valid, req_ready, req_signed;
   logic [31:0] req_dividend, req_divisor;
   logic [4:0]  req_tag;
   logic        flush, resp_valid, resp_ready;
   logic [31:0] resp_quot, resp_rem;
   logic [4:0]  resp_tag;
   logic        busy, err_timeout, div_start, div_signed;
   logic [31:0] div_dividend, div_divisor;
   logic        div_done;
   logic [31:0] div_quot, div_rem;

   div_seq_ctrl #(.DATA_W(32), .TAG_W(5), .TIMEOUT(T)) dut (
      .cpu_clk(clk), .cpu_rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
      .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
      .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_quot(resp_quot), .resp_rem(resp_rem), .resp_tag(resp_tag),
      .busy(busy), .err_timeout(err_timeout), .div_start(div_start), .div_signed(div_signed),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem)
   );

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic [4:0]  t;
   } exp_t;

   exp_t        expq[$];
   int          errors = 0;
   int          checks = 0;
   int          starts = 0;
   int          rsp_cnt = 0;
   int          vcyc = 0;
   int          div_lat = 4;
   logic [31:0] last_q, last_r;
   logic [4:0]  last_t;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stub divider: pulses done div_lat cycles after the start cycle (never when div_lat==0)
   initial begin
      logic        s_s;
      logic [31:0] a_s, b_s, q_s, r_s;
      div_done = 1'b0;
      div_quot = 32'd0;
      div_rem  = 32'd0;
      forever begin
         @(negedge clk);
         if (div_start === 1'b1) begin
            starts++;
            s_s = div_signed;
            a_s = div_dividend;
            b_s = div_divisor;
            if (div_lat != 0) begin
               repeat (div_lat) @(posedge clk);
               #1;
               model_div(s_s, a_s, b_s, q_s, r_s);
               div_quot = q_s;
               div_rem  = r_s;
               div_done = 1'b1;
               @(posedge clk);
               #1;
               div_done = 1'b0;
            end
         end
      end
   end

   // Per-cycle compare against the response scoreboard and interface invariants
   initial begin
      logic        prev_busy;
      logic [31:0] prev_dd, prev_dv;
      exp_t        e;
      prev_busy = 1'b0;
      prev_dd   = 32'd0;
      prev_dv   = 32'd0;
      forever begin
         @(negedge clk);
         if (rstn) begin
            check("ready_vs_busy", req_ready, busy == 1'b0);
            if (resp_valid) begin
               vcyc++;
               if (expq.size() == 0) begin
                  check("unexpected_resp", resp_valid, 1'b0);
               end else begin
                  e = expq[0];
                  check("resp_quot", resp_quot, e.q);
                  check("resp_rem", resp_rem, e.r);
                  check("resp_tag", resp_tag, e.t);
                  if (resp_ready && !flush) begin
                     last_q = resp_quot;
                     last_r = resp_rem;
                     last_t = resp_tag;
                     rsp_cnt++;
                  end
                  if (resp_ready || flush) void'(expq.pop_front());
               end
            end
            if (busy && prev_busy) begin
               check("dividend_stable", div_dividend, prev_dd);
               check("divisor_stable", div_divisor, prev_dv);
            end
         end
         prev_busy = busy;
         prev_dd   = div_dividend;
         prev_dv   = div_divisor;
      end
   end

   task automatic send(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic expect_resp);
      exp_t e;
      check("ready_before_send", req_ready, 1'b1);
      req_valid    = 1'b1;
      req_signed   = s;
      req_dividend = a;
      req_divisor  = b;
      req_tag      = t;
      if (expect_resp) begin
         model_div(s, a, b, e.q, e.r);
         e.t = t;
         expq.push_back(e);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound, input string name);
      int n = 0;
      while (!(req_ready && !resp_valid) && n < bound) begin
         tick();
         n++;
      end
      check(name, req_ready && !resp_valid, 1'b1);
   endtask

   task automatic wait_valid(input int bound, input string name);
      int n = 0;
      while (!resp_valid && n < bound) begin
         tick();
         n++;
      end
      check(name, resp_valid, 1'b1);
   endtask

   logic        tv_s[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [31:0] tv_a[7]  = '{32'd1000, 32'hFFFF_FF9C, 32'd100, 32'd0, 32'hFFFF_FFFB, 32'h8000_0000, 32'h7FFF_FFFF};
   logic [31:0] tv_b[7]  = '{32'd10, 32'd7, 32'hFFFF_FFF9, 32'd5, 32'd0, 32'd3, 32'hFFFF_FFFF};
   int          tv_lat[7] = '{18, 1, 5, 9, 0, 12, 2};

   initial begin
      int s0, rc0, v0, n;
      rstn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_dividend = 32'd0;
      req_divisor = 32'd0; req_tag = 5'd0; flush = 1'b0; resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_div_start", div_start, 1'b0);
      check("rst_err", err_timeout, 1'b0);
      check("rst_quot", resp_quot, 32'd0);
      check("rst_rem", resp_rem, 32'd0);
      check("rst_dividend", div_dividend, 32'd0);
      rstn = 1'b1;
      tick();

      // DIVU 100/7
      div_lat = 4; s0 = starts; v0 = vcyc;
      send(1'b0, 32'd100, 32'd7, 5'd5, 1'b1);
      check("launch_start", div_start, 1'b1);
      repeat (4) tick();
      check("lat_not_yet", resp_valid, 1'b0);
      tick();
      check("lat_valid", resp_valid, 1'b1);
      tick();
      check("after_hs_valid", resp_valid, 1'b0);
      check("after_hs_ready", req_ready, 1'b1);
      check("one_start", starts - s0, 1);
      check("valid_one_cycle", vcyc - v0, 1);
      check("q_100_7", last_q, 32'd14);
      check("r_100_7", last_r, 32'd2);
      check("tag_100_7", last_t, 5'd5);

      // DIV -7/2
      div_lat = 3;
      send(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
      wait_idle(40, "div_m7_done");
      check("q_m7_2", last_q, 32'hFFFF_FFFD);
      check("r_m7_2", last_r, 32'hFFFF_FFFF);
      check("signed_reg", div_signed, 1'b1);

      // DIVU 5/0
      s0 = starts;
      send(1'b0, 32'd5, 32'd0, 5'd3, 1'b1);
      check("dz_valid_next", resp_valid, 1'b1);
      check("dz_no_start_now", div_start, 1'b0);
      tick();
      check("dz_no_start", starts - s0, 0);
      check("q_5_0", last_q, 32'hFFFF_FFFF);
      check("r_5_0", last_r, 32'd5);

      // DIVU 3/9, minimum latency
      div_lat = 1;
      send(1'b0, 32'd3, 32'd9, 5'd1, 1'b1);
      check("min_launch_valid", resp_valid, 1'b0);
      check("min_start", div_start, 1'b1);
      tick();
      check("min_wait_valid", resp_valid, 1'b0);
      tick();
      check("min_resp_valid", resp_valid, 1'b1);
      tick();
      check("q_3_9", last_q, 32'd0);
      check("r_3_9", last_r, 32'd3);

      // Flush in WAIT -> DRAIN until done
      div_lat = 6; rc0 = rsp_cnt;
      send(1'b0, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b0);
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("drain_ready_low", req_ready, 1'b0);
         tick();
      end
      check("drain_back_idle", req_ready, 1'b1);
      check("drain_no_resp", rsp_cnt - rc0, 0);

      // Flush in LAUNCH suppresses the start pulse
      s0 = starts;
      send(1'b0, 32'd10, 32'd2, 5'd4, 1'b0);
      flush = 1'b1;
      #1;
      check("launch_flush_start", div_start, 1'b0);
      tick();
      flush = 1'b0;
      check("launch_flush_idle", req_ready, 1'b1);
      check("launch_flush_nostart", starts - s0, 0);

      // Flush together with done
      div_lat = 3;
      send(1'b0, 32'd20, 32'd4, 5'd6, 1'b0);
      repeat (3) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_done_idle", req_ready, 1'b1);
      check("flush_done_novalid", resp_valid, 1'b0);

      // Flush in RESP wins over resp_ready
      resp_ready = 1'b0; div_lat = 2; rc0 = rsp_cnt;
      send(1'b0, 32'd20, 32'd3, 5'd7, 1'b1);
      wait_valid(30, "resp_flush_reach");
      flush = 1'b1; resp_ready = 1'b1;
      tick();
      flush = 1'b0;
      check("resp_flush_valid", resp_valid, 1'b0);
      check("resp_flush_ready", req_ready, 1'b1);
      check("resp_flush_nohs", rsp_cnt - rc0, 0);

      // Backpressure
      resp_ready = 1'b0; rc0 = rsp_cnt;
      send(1'b0, 32'd50, 32'd5, 5'd8, 1'b1);
      wait_valid(30, "bp_reach");
      for (int k = 0; k < 5; k++) begin
         check("bp_valid_held", resp_valid, 1'b1);
         check("bp_ready_low", req_ready, 1'b0);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      check("bp_release_valid", resp_valid, 1'b0);
      check("bp_release_ready", req_ready, 1'b1);
      check("bp_one_hs", rsp_cnt - rc0, 1);
      check("q_50_5", last_q, 32'd10);

      // Vector table, back-to-back, latency from accept to resp_valid
      for (int i = 0; i < 7; i++) begin
         div_lat = tv_lat[i];
         send(tv_s[i], tv_a[i], tv_b[i], 5'(i + 10), 1'b1);
         n = 0;
         while (!resp_valid && n < 30) begin
            tick();
            n++;
         end
         check("vec_latency", n, (tv_b[i] == 32'd0) ? 0 : tv_lat[i] + 1);
         tick();
      end
      wait_idle(5, "vec_idle");

      // Watchdog
      div_lat = 0;
      send(1'b0, 32'd9, 32'd3, 5'd1, 1'b0);
      repeat (T + 1) tick();
      check("wdog_not_yet", err_timeout, 1'b0);
      check("wdog_still_busy", busy, 1'b1);
      tick();
      check("wdog_err", err_timeout, 1'b1);
      check("wdog_idle", req_ready, 1'b1);
      div_lat = 2;
      send(1'b0, 32'd8, 32'd2, 5'd2, 1'b1);
      wait_idle(30, "wdog_next_done");
      check("wdog_sticky", err_timeout, 1'b1);
      check("q_8_2", last_q, 32'd4);

      // Reset in WAIT abandons the op
      div_lat = 8; rc0 = rsp_cnt;
      send(1'b0, 32'd77, 32'd7, 5'd3, 1'b0);
      repeat (3) tick();
      rstn = 1'b0;
      #2;
      check("midrst_valid", resp_valid, 1'b0);
      check("midrst_ready", req_ready, 1'b1);
      check("midrst_err", err_timeout, 1'b0);
      check("midrst_dividend", div_dividend, 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (12) tick();
      check("postrst_busy", busy, 1'b0);
      check("postrst_err", err_timeout, 1'b0);
      check("postrst_nohs", rsp_cnt - rc0, 0);
      check("queue_empty", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
